nn_stream_loader: RTL and testbench
===================================

Name: nn_stream_loader

Overview:
- Upstream stage of mnist_nn; drives its off-chip load port and its compute handshake.
- Accepts a byte stream (valid/ready) and serialises it LSB-first into the 1-bit weight memory, then the 1-bit input memory.
- Then hands memory ownership to the compute module, pulses compute, and waits for compute_finish.
- Reports done plus the compute cycle count.

Parameters:
- W_ADDR_LEN, 20, weight address width.
- X_ADDR_LEN, 10, input address width.
- W_SEL_LEN, 2, weight bank select width.
- X_SEL_LEN, 2, input bank select width.
- W_LOAD_LEN, 100352, weight bits to load (1..2^W_ADDR_LEN).
- X_LOAD_LEN, 784, input bits to load (1..2^X_ADDR_LEN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE or DONE.
- w_sel_cfg  in  W_SEL_LEN  weight bank; sampled at accepted start.
- x_sel_cfg  in  X_SEL_LEN  input bank; sampled at accepted start.
- s_data  in  8  stream byte.
- s_valid  in  1  byte valid.
- s_ready  out  1  byte accepted on s_valid & s_ready at the rising edge.
- load_compute_ctrl  out  1  1 = off-chip port owns memory; 0 = compute owns it.
- en_compute  out  1  compute enable.
- compute_finish  in  1  from compute module.
- w_wq_oc  out  1  weight write strobe.
- w_addr_oc  out  W_ADDR_LEN  weight write address.
- x_wq_oc  out  1  input write strobe.
- x_addr_oc  out  X_ADDR_LEN  input write address.
- wx_write_oc  out  1  write data bit, shared.
- w_sel_oc  out  W_SEL_LEN  registered w_sel_cfg.
- x_sel_oc  out  X_SEL_LEN  registered x_sel_cfg.
- busy  out  1  high in LOAD_W, LOAD_X, COMPUTE.
- done  out  1  high in DONE.
- compute_cycles  out  32  cycles spent in COMPUTE, last run.

Behaviour:
- All outputs are registered.
- Reset values: load_compute_ctrl=1, en_compute=0, wq strobes=0, addresses=0, wx_write_oc=0, sel outputs=0, s_ready=0, busy=0, done=0, compute_cycles=0, state=IDLE, shift register empty.
- Reset mid-operation aborts immediately to these values. Partially written memory is not cleared.
- States: IDLE, LOAD_W, LOAD_X, COMPUTE, DONE.
- IDLE/DONE -> LOAD_W on start: write address counter=0, sel outputs latched, done cleared. start is ignored in the other states.
- Serialiser:
  - s_ready=1 in LOAD_W/LOAD_X when the shift register is empty, or when its 8th bit is being presented this cycle.
  - A byte accepted at edge k presents bit i in cycle k+1+i, i=0..7.
  - Back-to-back bytes give one bit per cycle with no gaps.
  - s_valid low leaves gaps with strobe 0; the address does not advance.
- Write cycle (LOAD_W): w_wq_oc=1, w_addr_oc=counter, wx_write_oc=bit. Counter increments after each write. x_wq_oc=0.
- Write cycle (LOAD_X): same using the x_* outputs. w_wq_oc=0.
- After write number W_LOAD_LEN (address W_LOAD_LEN-1):
  - Remaining bits of the current byte are discarded and the shift register is emptied.
  - State goes to LOAD_X with counter=0. s_ready is 0 in that transition cycle.
- Bytes do not straddle the W/X boundary.
- After write X_LOAD_LEN-1, the state goes to COMPUTE and leftover bits are discarded.
- Entry to COMPUTE: load_compute_ctrl=0 and en_compute=1 from the first COMPUTE cycle.
  - compute_cycles resets to 0, then increments each COMPUTE cycle and saturates at 2^32-1.
- compute_finish sampled high in COMPUTE -> DONE next edge: en_compute=0, load_compute_ctrl=1, done=1.
  - compute_cycles holds the count.
  - compute_finish outside COMPUTE is ignored.
- DONE is held until start (new run) or rst.
- s_ready=0 in IDLE, COMPUTE and DONE. Stream bytes offered then are not consumed.
- Address counter width is the address width. Counter wrap is unreachable given the parameter ranges.

Test Plan:
- Reset: assert rst mid-LOAD_W -> outputs take reset values asynchronously (load_compute_ctrl=1, strobes 0), state IDLE, s_ready=0.
- Basic load (W_LOAD_LEN=16, X_LOAD_LEN=10): start, stream 0xA5,0x3C,0xFF,0x81 back-to-back.
  - w writes at addr 0..15 carry bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on consecutive cycles.
  - x addr 0..7 =1; x addr 8 =1, 9 =0; remaining 6 bits of 0x81 discarded.
- Gaps: s_valid low 3 cycles between bytes -> strobes low 3 cycles, addresses contiguous, no bit lost.
- Boundary discard (W_LOAD_LEN=12): second byte's upper 4 bits produce no writes; the next byte lands at x addr 0; s_ready=0 in the transition cycle.
- Compute handshake: after loads, load_compute_ctrl=0 and en_compute=1. Raise compute_finish after 50 cycles -> DONE with en_compute=0, load_compute_ctrl=1, done=1, compute_cycles=50.
- Restart: start in DONE with new sel_cfg -> sel outputs update, addresses restart at 0, done=0. start asserted during COMPUTE is ignored.

Source files
------------

// File: rtl/nn_stream_loader.sv
// nn_stream_loader: serialises a byte stream LSB-first into weight then input memory, then runs the compute handshake.
module nn_stream_loader #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int W_LOAD_LEN = 100352,
  parameter int X_LOAD_LEN = 784
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W_SEL_LEN-1:0]  w_sel_cfg,
  input  logic [X_SEL_LEN-1:0]  x_sel_cfg,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  load_compute_ctrl,
  output logic                  en_compute,
  input  logic                  compute_finish,
  output logic                  w_wq_oc,
  output logic [W_ADDR_LEN-1:0] w_addr_oc,
  output logic                  x_wq_oc,
  output logic [X_ADDR_LEN-1:0] x_addr_oc,
  output logic                  wx_write_oc,
  output logic [W_SEL_LEN-1:0]  w_sel_oc,
  output logic [X_SEL_LEN-1:0]  x_sel_oc,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           compute_cycles
);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, DONE} state_t;
  localparam logic [W_ADDR_LEN-1:0] W_LAST = W_ADDR_LEN'(W_LOAD_LEN - 1);
  localparam logic [X_ADDR_LEN-1:0] X_LAST = X_ADDR_LEN'(X_LOAD_LEN - 1);
  state_t st_q, st_d;
  logic [6:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic fin_q, fin_d;
  logic [W_ADDR_LEN-1:0] w_cnt_q, w_cnt_d, w_addr_q, w_addr_d;
  logic [X_ADDR_LEN-1:0] x_cnt_q, x_cnt_d, x_addr_q, x_addr_d;
  logic [W_SEL_LEN-1:0] w_sel_q, w_sel_d;
  logic [X_SEL_LEN-1:0] x_sel_q, x_sel_d;
  logic s_ready_q, s_ready_d, lcc_q, lcc_d, en_q, en_d, w_wq_q, w_wq_d, x_wq_q, x_wq_d;
  logic wx_q, wx_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] cc_q, cc_d;
  logic loading, have, bit_v;
  // fin_q marks the cycle presenting a phase's final write; the state advances only after it
  always_comb begin
    st_d = st_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    fin_d = 1'b0;
    w_cnt_d = w_cnt_q;
    x_cnt_d = x_cnt_q;
    w_addr_d = w_addr_q;
    x_addr_d = x_addr_q;
    w_sel_d = w_sel_q;
    x_sel_d = x_sel_q;
    w_wq_d = 1'b0;
    x_wq_d = 1'b0;
    wx_d = wx_q;
    cc_d = cc_q;
    loading = st_q == LOAD_W || st_q == LOAD_X;
    have = loading && !fin_q && (cnt_q != 4'd0 || (s_ready_q && s_valid));
    bit_v = cnt_q != 4'd0 ? sr_q[0] : s_data[0];
    if (have) begin
      sr_d = cnt_q != 4'd0 ? sr_q >> 1 : s_data[7:1];
      cnt_d = cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd7;
      wx_d = bit_v;
      if (st_q == LOAD_W) begin
        w_wq_d = 1'b1;
        w_addr_d = w_cnt_q;
        w_cnt_d = w_cnt_q + 1'b1;
        fin_d = w_cnt_q == W_LAST;
      end else begin
        x_wq_d = 1'b1;
        x_addr_d = x_cnt_q;
        x_cnt_d = x_cnt_q + 1'b1;
        fin_d = x_cnt_q == X_LAST;
      end
      cnt_d = fin_d ? 4'd0 : cnt_d;
    end
    if (fin_q) begin
      st_d = st_q == LOAD_W ? LOAD_X : COMPUTE;
      cc_d = st_q == LOAD_W ? cc_q : 32'd0;
    end
    if (st_q == COMPUTE) begin
      cc_d = &cc_q ? cc_q : cc_q + 32'd1;
      st_d = compute_finish ? DONE : st_q;
    end
    if ((st_q == IDLE || st_q == DONE) && start) begin
      st_d = LOAD_W;
      cnt_d = 4'd0;
      w_cnt_d = '0;
      x_cnt_d = '0;
      w_addr_d = '0;
      x_addr_d = '0;
      w_sel_d = w_sel_cfg;
      x_sel_d = x_sel_cfg;
    end
    s_ready_d = (st_d == LOAD_W || st_d == LOAD_X) && cnt_d == 4'd0 && !fin_d;
    lcc_d = st_d != COMPUTE;
    en_d = st_d == COMPUTE;
    busy_d = st_d == LOAD_W || st_d == LOAD_X || st_d == COMPUTE;
    done_d = st_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      fin_q <= 1'b0;
      w_cnt_q <= '0;
      x_cnt_q <= '0;
      w_addr_q <= '0;
      x_addr_q <= '0;
      w_sel_q <= '0;
      x_sel_q <= '0;
      s_ready_q <= 1'b0;
      lcc_q <= 1'b1;
      en_q <= 1'b0;
      w_wq_q <= 1'b0;
      x_wq_q <= 1'b0;
      wx_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cc_q <= '0;
    end else begin
      st_q <= st_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      fin_q <= fin_d;
      w_cnt_q <= w_cnt_d;
      x_cnt_q <= x_cnt_d;
      w_addr_q <= w_addr_d;
      x_addr_q <= x_addr_d;
      w_sel_q <= w_sel_d;
      x_sel_q <= x_sel_d;
      s_ready_q <= s_ready_d;
      lcc_q <= lcc_d;
      en_q <= en_d;
      w_wq_q <= w_wq_d;
      x_wq_q <= x_wq_d;
      wx_q <= wx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cc_q <= cc_d;
    end
  end
  assign s_ready = s_ready_q;
  assign load_compute_ctrl = lcc_q;
  assign en_compute = en_q;
  assign w_wq_oc = w_wq_q;
  assign w_addr_oc = w_addr_q;
  assign x_wq_oc = x_wq_q;
  assign x_addr_oc = x_addr_q;
  assign wx_write_oc = wx_q;
  assign w_sel_oc = w_sel_q;
  assign x_sel_oc = x_sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign compute_cycles = cc_q;
endmodule

// File: tb/tb_nn_stream_loader.sv
// tb_nn_stream_loader: two loader instances (16-bit and 12-bit weight loads) with a write scoreboard.
module tb_nn_stream_loader;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic start_a = 0, start_b = 0, s_valid = 0, compute_finish = 0;
  logic [7:0] s_data = 0;
  logic [1:0] w_sel_cfg = 0, x_sel_cfg = 0;
  logic s_ready_a, lcc_a, en_a, w_wq_a, x_wq_a, wx_a, busy_a, done_a;
  logic s_ready_b, lcc_b, en_b, w_wq_b, x_wq_b, wx_b, busy_b, done_b;
  logic [19:0] w_addr_a, w_addr_b;
  logic [9:0] x_addr_a, x_addr_b;
  logic [1:0] w_sel_a, x_sel_a, w_sel_b, x_sel_b;
  logic [31:0] cc_a, cc_b;
  int tests = 0, fails = 0, cyc = 0;
  bit which = 0, mon_en = 1;
  logic [22:0] exp_q[$];
  int t_w[16];

  nn_stream_loader #(.W_LOAD_LEN(16), .X_LOAD_LEN(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .w_sel_cfg(w_sel_cfg), .x_sel_cfg(x_sel_cfg),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a), .load_compute_ctrl(lcc_a),
    .en_compute(en_a), .compute_finish(compute_finish), .w_wq_oc(w_wq_a), .w_addr_oc(w_addr_a),
    .x_wq_oc(x_wq_a), .x_addr_oc(x_addr_a), .wx_write_oc(wx_a), .w_sel_oc(w_sel_a),
    .x_sel_oc(x_sel_a), .busy(busy_a), .done(done_a), .compute_cycles(cc_a));

  nn_stream_loader #(.W_LOAD_LEN(12), .X_LOAD_LEN(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .w_sel_cfg(w_sel_cfg), .x_sel_cfg(x_sel_cfg),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b), .load_compute_ctrl(lcc_b),
    .en_compute(en_b), .compute_finish(compute_finish), .w_wq_oc(w_wq_b), .w_addr_oc(w_addr_b),
    .x_wq_oc(x_wq_b), .x_addr_oc(x_addr_b), .wx_write_oc(wx_b), .w_sel_oc(w_sel_b),
    .x_sel_oc(x_sel_b), .busy(busy_b), .done(done_b), .compute_cycles(cc_b));

  logic c_rdy, c_lcc, c_en, c_busy, c_done;
  logic [1:0] c_wsel, c_xsel;
  logic [31:0] c_cc;
  always_comb begin
    c_rdy = which ? s_ready_b : s_ready_a;
    c_lcc = which ? lcc_b : lcc_a;
    c_en = which ? en_b : en_a;
    c_busy = which ? busy_b : busy_a;
    c_done = which ? done_b : done_a;
    c_wsel = which ? w_sel_b : w_sel_a;
    c_xsel = which ? x_sel_b : x_sel_a;
    c_cc = which ? cc_b : cc_a;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input bit d, input bit isx, input int base, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({d, isx, 20'(base + i), b[i]});
  endtask

  task automatic chk_wr(input bit d, input bit isx, input logic [19:0] a, input logic b);
    logic [22:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL write: got dut=%0d x=%0d addr=%0d bit=%0d expected no write", d, isx, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e !== {d, isx, a, b}) begin
        fails++;
        $display("FAIL write: got dut=%0d x=%0d addr=%0d bit=%0d expected dut=%0d x=%0d addr=%0d bit=%0d",
                 d, isx, a, b, e[22], e[21], e[20:1], e[0]);
      end
    end
  endtask

  // scoreboard monitor: every write strobe consumes one expected entry
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (w_wq_a) begin
        chk_wr(0, 0, w_addr_a, wx_a);
        if (w_addr_a < 20'd16) t_w[w_addr_a[3:0]] = cyc;
      end
      if (x_wq_a) chk_wr(0, 1, {10'd0, x_addr_a}, wx_a);
      if (w_wq_b) begin
        chk_wr(1, 0, w_addr_b, wx_b);
        if (w_addr_b == 20'd11) check("b_ready_in_transition", 32'(s_ready_b), 0);
      end
      if (x_wq_b) chk_wr(1, 1, {10'd0, x_addr_b}, wx_b);
    end
  end

  task automatic wait_rdy();
    int n = 0;
    while (!c_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_wait", 32'(c_rdy), 1);
  endtask

  task automatic send(input logic [7:0] b);
    s_data = b;
    s_valid = 1;
    wait_rdy();
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic do_start(input bit d, input logic [1:0] ws, input logic [1:0] xs);
    w_sel_cfg = ws;
    x_sel_cfg = xs;
    which = d;
    if (d) start_b = 1; else start_a = 1;
    @(negedge clk);
    start_a = 0;
    start_b = 0;
    w_sel_cfg = ~ws;
    x_sel_cfg = ~xs;
    check("start_busy", 32'(c_busy), 1);
    check("start_done", 32'(c_done), 0);
    check("start_wsel", 32'(c_wsel), 32'(ws));
    check("start_xsel", 32'(c_xsel), 32'(xs));
    check("start_ready", 32'(c_rdy), 1);
  endtask

  task automatic run_compute(input int n, input bit poke);
    int k = 0;
    while (!c_en && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("compute_en", 32'(c_en), 1);
    check("compute_lcc", 32'(c_lcc), 0);
    check("writes_drained", exp_q.size(), 0);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      start_a = poke && i == 5 && !which;
      start_b = poke && i == 5 && which;
    end
    start_a = 0;
    start_b = 0;
    compute_finish = 1;
    @(negedge clk);
    compute_finish = 0;
    check("done_flag", 32'(c_done), 1);
    check("done_en", 32'(c_en), 0);
    check("done_lcc", 32'(c_lcc), 1);
    check("done_busy", 32'(c_busy), 0);
    check("compute_cycles", c_cc, n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_lcc", 32'(lcc_a), 1);
    check("rst_en", 32'(en_a), 0);
    check("rst_wq", {30'd0, w_wq_a, x_wq_a}, 0);
    check("rst_ready", 32'(s_ready_a), 0);
    check("rst_busy_done", {30'd0, busy_a, done_a}, 0);
    check("rst_cc", cc_a, 0);
    check("rst_addr", {2'd0, x_addr_a, w_addr_a}, 0);
    check("rst_sel", {28'd0, w_sel_a, x_sel_a}, 0);
    rst = 0;
    @(negedge clk);
    // back-to-back load: A5,3C to weights, FF,81 to inputs (81 keeps only 2 bits)
    push_byte(0, 0, 0, 8'hA5, 8);
    push_byte(0, 0, 8, 8'h3C, 8);
    push_byte(0, 1, 0, 8'hFF, 8);
    push_byte(0, 1, 8, 8'h81, 2);
    do_start(0, 2'd2, 2'd1);
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    send(8'h81);
    run_compute(50, 1);
    check("b2b_span", t_w[15] - t_w[0], 15);
    s_data = 8'hEE;
    s_valid = 1;
    repeat (3) @(negedge clk);
    check("done_ready", 32'(c_rdy), 0);
    s_valid = 0;
    // restart with a 3-cycle gap between the two weight bytes
    push_byte(0, 0, 0, 8'h5A, 8);
    push_byte(0, 0, 8, 8'hC3, 8);
    push_byte(0, 1, 0, 8'h0F, 8);
    push_byte(0, 1, 8, 8'h01, 2);
    do_start(0, 2'd1, 2'd3);
    send(8'h5A);
    wait_rdy();
    repeat (3) @(negedge clk);
    send(8'hC3);
    send(8'h0F);
    send(8'h01);
    run_compute(5, 0);
    check("gap_span", t_w[8] - t_w[7], 4);
    check("post_gap_span", t_w[15] - t_w[8], 7);
    // 12-bit weight load: upper nibble of 4B is discarded, E7 starts the inputs
    push_byte(1, 0, 0, 8'h96, 8);
    push_byte(1, 0, 8, 8'h4B, 4);
    push_byte(1, 1, 0, 8'hE7, 8);
    push_byte(1, 1, 8, 8'h02, 2);
    do_start(1, 2'd3, 2'd2);
    send(8'h96);
    send(8'h4B);
    send(8'hE7);
    send(8'h02);
    run_compute(3, 0);
    // asynchronous reset in the middle of a weight load
    mon_en = 0;
    do_start(1, 2'd0, 2'd1);
    send(8'hAA);
    repeat (2) @(negedge clk);
    check("midload_wq", 32'(w_wq_b), 1);
    #2 rst = 1;
    #1;
    check("arst_lcc", 32'(lcc_b), 1);
    check("arst_wq", {30'd0, w_wq_b, x_wq_b}, 0);
    check("arst_ready", 32'(s_ready_b), 0);
    check("arst_busy_done", {29'd0, busy_b, done_b, en_b}, 0);
    check("arst_addr_sel", {w_sel_b, x_sel_b, w_addr_b}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("idle_after_rst", {30'd0, busy_b, s_ready_b}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
